// File: rtl/axis_stream_checker.sv
// AXI4-Stream sink that checks packets against a 0,1,2,... counting pattern with tlast on the last beat.
// Optional back-pressure pattern enabled by defining AXIS_CHECK_THROTTLE_EN.
module axis_stream_checker #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  enable,
    input  logic [LEN_WIDTH-1:0]  pkt_len,
    input  logic [7:0]            throttle_mask,
    output logic                  pkt_done,
    output logic [CNT_WIDTH-1:0]  pkt_count,
    output logic [CNT_WIDTH-1:0]  data_err_cnt,
    output logic [CNT_WIDTH-1:0]  len_err_cnt,
    output logic                  data_err,
    output logic                  len_err
);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [LEN_WIDTH-1:0] LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

    state_t               state;
    logic [LEN_WIDTH-1:0] idx;
    logic [LEN_WIDTH-1:0] len_q;
    logic                 len_flagged;
    logic                 tready_next;

    logic                  accept;
    logic [LEN_WIDTH-1:0]  cur_len;
    logic [DATA_WIDTH-1:0] exp_data;
    logic [LEN_WIDTH:0]    idx_p1;
    logic [LEN_WIDTH:0]    len_ext;
    logic                  data_bad;
    logic                  early;
    logic                  missing;
    logic                  len_bad;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    // Handshake: a beat transfers on a rising edge where tvalid and tready are both high;
    // tready is a register and never looks at tvalid.
    assign accept = s_axis_tvalid && s_axis_tready;

    // The length is latched on beat 0, so the first beat must see pkt_len directly.
    assign cur_len  = (idx == '0) ? pkt_len : len_q;
    assign exp_data = DATA_WIDTH'(idx);
    assign idx_p1   = {1'b0, idx} + {1'b0, LEN_ONE};
    assign len_ext  = {1'b0, cur_len};
    assign data_bad = (s_axis_tdata != exp_data);
    assign early    = s_axis_tlast && (idx_p1 < len_ext);
    assign missing  = !s_axis_tlast && (idx_p1 == len_ext);
    assign len_bad  = (cur_len != '0) && !len_flagged && (early || missing);

`ifdef AXIS_CHECK_THROTTLE_EN
    logic [2:0] phase;
    assign tready_next = enable && throttle_mask[phase];
`else
    logic unused_throttle;
    assign unused_throttle = ^throttle_mask;
    assign tready_next     = enable;
`endif

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state         <= ST_IDLE;
            s_axis_tready <= 1'b0;
            idx           <= '0;
            len_q         <= '0;
            len_flagged   <= 1'b0;
            pkt_done      <= 1'b0;
            pkt_count     <= '0;
            data_err_cnt  <= '0;
            len_err_cnt   <= '0;
            data_err      <= 1'b0;
            len_err       <= 1'b0;
`ifdef AXIS_CHECK_THROTTLE_EN
            phase         <= 3'd0;
`endif
        end else begin
            s_axis_tready <= tready_next;
            pkt_done      <= accept && s_axis_tlast;

            case (state)
                ST_IDLE: if (enable) state <= ST_RUN;
                ST_RUN: begin
                    if (!enable) state <= ST_IDLE;
`ifdef AXIS_CHECK_THROTTLE_EN
                    phase <= phase + 3'd1;
`endif
                end
                default: state <= ST_IDLE;
            endcase

            if (accept) begin
                if (idx == '0) len_q <= pkt_len;
                if (data_bad) begin
                    data_err_cnt <= sat_inc(data_err_cnt);
                    data_err     <= 1'b1;
                end
                if (len_bad) begin
                    len_err_cnt <= sat_inc(len_err_cnt);
                    len_err     <= 1'b1;
                end
                if (s_axis_tlast) begin
                    idx         <= '0;
                    len_flagged <= 1'b0;
                    pkt_count   <= sat_inc(pkt_count);
                end else begin
                    idx <= idx + LEN_ONE;
                    if (len_bad) len_flagged <= 1'b1;
                end
            end
        end
    end

endmodule
